// File: rtl/cpu_pkg.sv
// Shared CPU types for the HI/LO multiply/divide path.
package cpu_pkg;

    // Encoding equals funct[1:0] of the R-type opcode; bit0 selects unsigned.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_t;

    localparam int MD_ITER = 32;

    function automatic logic md_is_div(input md_op_t o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_t o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: magnitude of signed operands, sign correction of results.
// Latency: combinational.
// Backpressure: none.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// Latency: 33 cycles from accepted start to done (32 CALC iterations + 1 FIX).
// Backpressure: busy stalls the pipeline; start/mthi/mtlo are ignored while busy.
module mul_div_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state;
    md_op_t      op_q;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        sign_a;
    logic        sign_b;
    logic        b_zero;

    md_op_t      op_in;
    logic        in_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign op_in  = md_op_t'(op);
    assign in_div = md_is_div(op_in);
    assign a_neg  = md_is_signed(op_in) & a[31];
    assign b_neg  = md_is_signed(op_in) & b[31];

    md_sign_fix #(.W(32)) u_abs_a (.val(a), .neg(a_neg), .res(a_mag));
    md_sign_fix #(.W(32)) u_abs_b (.val(b), .neg(b_neg), .res(b_mag));

    // One iteration step. acc is {upper, lower}: for multiply the lower half is
    // the multiplier being shifted out; for divide it is the dividend being
    // shifted into the partial remainder while quotient bits shift in.
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] acc_nxt;

    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + {1'b0, opnd};
        div_sh  = {acc[63:32], acc[31]};
        div_ge  = (div_sh >= {1'b0, opnd});
        div_sub = div_sh[31:0] - opnd;
        acc_nxt = {1'b0, acc[63:1]};
        if (md_is_div(op_q)) begin
            if (div_ge)
                acc_nxt = {div_sub, acc[30:0], 1'b1};
            else
                acc_nxt = {div_sh[31:0], acc[30:0], 1'b0};
        end else if (acc[0]) begin
            acc_nxt = {mul_sum, acc[31:1]};
        end
    end

    // Result correction. With a zero divisor the restoring loop leaves |a| in
    // the remainder, so applying sign(a) returns a unchanged in HI.
    logic        res_signed;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign res_signed = md_is_signed(op_q);

    md_sign_fix #(.W(64)) u_fix_prod (.val(acc),        .neg(res_signed & (sign_a ^ sign_b)), .res(prod_fix));
    md_sign_fix #(.W(32)) u_fix_quo  (.val(acc[31:0]),  .neg(res_signed & (sign_a ^ sign_b)), .res(quo_fix));
    md_sign_fix #(.W(32)) u_fix_rem  (.val(acc[63:32]), .neg(res_signed & sign_a),            .res(rem_fix));

    always_comb begin
        res_hi = prod_fix[63:32];
        res_lo = prod_fix[31:0];
        if (md_is_div(op_q)) begin
            res_hi = rem_fix;
            res_lo = b_zero ? 32'hFFFF_FFFF : quo_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            op_q   <= MD_MULT;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start && !flush) begin
                        op_q   <= op_in;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        b_zero <= (b == 32'd0);
                        cnt    <= '0;
                        opnd   <= in_div ? b_mag : a_mag;
                        acc    <= {32'd0, (in_div ? a_mag : b_mag)};
                        busy   <= 1'b1;
                        state  <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'(MD_ITER - 1))
                            state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: issued ops push expected {hi,lo}; a monitor pops on done.
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int busy_run = 0;
    int last_busy_run = 0;
    logic prev_done = 1'b0;
    logic [63:0] exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares each done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: hi=%h lo=%h with no op pending", hi, lo);
            end else begin
                check("result_hi_lo", {hi, lo}, exp_q.pop_front());
                check("busy_low_at_done", 64'(busy), 64'd0);
            end
            if (prev_done) begin
                total++;
                bad++;
                $display("FAIL done_width: done high 2 cycles, expected 1");
            end
        end
        prev_done = done;
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
    end

    // Drives start for one edge; called at negedge+1.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit expect_res, input logic [63:0] e);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        if (expect_res) exp_q.push_back(e);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk); #1;
            seen = done;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: done not seen within 60 cycles, expected a done pulse", nm);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    int dc;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        @(negedge clk); #1;
        check("reset_state", {28'd0, busy, done, 2'b00, hi, lo}, 64'd0);
        rst_n = 1'b1;
        tick(1);

        // MULTU max*max, busy length, then back-to-back MULT in the done cycle
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        wait_done("multu");
        check("busy_cycles", 64'(last_busy_run), 64'd33);
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        check("b2b_accepted_busy", 64'(busy), 64'd1);
        check("done_one_cycle", 64'(done), 64'd0);
        wait_done("mult");
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        wait_done("mult_min");

        // Division incl. sign rules and overflow case
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done("div_neg");
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD);
        wait_done("div_negb");
        issue(2'b11, 32'd7, 32'd2, 1'b1, 64'h0000_0001_0000_0003);
        wait_done("divu");
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
        wait_done("div_ovf");

        // Divide by zero
        issue(2'b11, 32'd5, 32'd0, 1'b1, 64'h0000_0005_FFFF_FFFF);
        wait_done("divu_zero");
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1, 64'hFFFF_FFF9_FFFF_FFFF);
        wait_done("div_zero");

        // MTHI/MTLO in idle
        mthi = 1'b1; wdata = 32'h11;
        tick(1);
        mthi = 1'b0;
        check("mthi", 64'(hi), 64'h11);
        mtlo = 1'b1; wdata = 32'h22;
        tick(1);
        mtlo = 1'b0;
        check("mtlo", 64'(lo), 64'h22);

        // Start DIV, ignored start+mthi at cycle 5, flush at cycle 10
        dc = done_cnt;
        issue(2'b10, 32'd100, 32'd3, 1'b0, 64'd0);
        tick(3);
        start = 1'b1; mthi = 1'b1; wdata = 32'h99; op = 2'b01;
        tick(1);
        start = 1'b0; mthi = 1'b0;
        check("mthi_ignored_busy", 64'(hi), 64'h11);
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi_lo", {hi, lo}, 64'h0000_0011_0000_0022);
        tick(40);
        check("flush_no_done", 64'(done_cnt - dc), 64'd0);
        check("flush_stays_idle", 64'(busy), 64'd0);

        // flush with start in idle suppresses start
        flush = 1'b1;
        issue(2'b01, 32'd2, 32'd2, 1'b0, 64'd0);
        flush = 1'b0;
        check("flush_start_suppressed", 64'(busy), 64'd0);

        // mtlo with start: write lands now, result overwrites later
        mtlo = 1'b1; wdata = 32'h55;
        issue(2'b01, 32'd6, 32'd7, 1'b1, 64'h0000_0000_0000_002A);
        mtlo = 1'b0;
        check("mtlo_with_start", 64'(lo), 64'h55);
        wait_done("multu_small");

        // Async reset mid-CALC
        dc = done_cnt;
        issue(2'b01, 32'd5, 32'd6, 1'b0, 64'd0);
        tick(10);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {28'd0, busy, done, 2'b00, hi, lo}, 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        issue(2'b01, 32'd3, 32'd4, 1'b1, 64'h0000_0000_0000_000C);
        wait_done("multu_after_reset");
        check("reset_killed_op_no_done", 64'(done_cnt - dc), 64'd1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
